uart_receiver: RTL

// - Receive side of the UART link. Counterpart of the transmit-side baud generator and transmitter.
// - Recovers 8N1 serial frames (1 start, DATA_BITS data LSB-first, 1 stop) from the rx pin.
// - Uses its own bit-period counter and samples each bit at its centre.
// - Presents each byte on a valid/ready interface and flags framing and overrun errors.

---
 rtl/uart_receiver.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// UART receive path: recovers LSB-first frames from an asynchronous rx line, samples mid-bit,
// and hands bytes out on a valid/ready interface with framing and overrun error pulses.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 1000,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DATA_BITS - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 rx_meta_q, rx_s_q;
  logic                 load;
  logic                 out_free;
  logic [DATA_BITS:0]   shift_in;

  // Two-flop synchronizer; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign out_free = !rx_valid_q || rx_ready;
  assign shift_in = {rx_s_q, shreg_q};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    load        = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) begin
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntHalf) begin
          // A start bit that is gone by mid-bit is treated as a glitch.
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          shreg_d = shift_in[DATA_BITS:1];
          idx_d   = idx_q + IdxW'(1);
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end
        end
      end
      StStop: begin
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
            if (out_free) begin
              load = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        cnt_d = '0;
        if (rx_s_q) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // A load on the same edge as an accept keeps rx_valid asserted for the new byte.
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    if (load) begin
      rx_data_d  = shreg_q;
      rx_valid_d = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
